vga_clk_divider: RTL

Parametrised, glitch-free, run-time selectable clock-enable and divided-clock generator. It produces the pixel/line timing enables for the VGA pipeline from the single system clock. Mode selects either a power-of-two ratio or a programmable divisor. Ratio changes take effect only at period boundaries, so downstream timing never sees a runt or stretched period.

---
 rtl/vga_clk_divider_pkg.sv | 30 +++
 rtl/vga_clk_divider_if.sv | 28 ++
 rtl/vga_div_counter.sv | 54 +++++
 rtl/vga_clk_divider.sv | 121 ++++++++++++
 4 files changed

// File: rtl/vga_clk_divider_pkg.sv
// rtl/vga_clk_divider_pkg.sv - mode encoding, FSM states and mode->divisor decode for vga_clk_divider
// Contents: MODE_OFF/MODE_PROG constants, state_t {IDLE, RUN}, decode_div().
package vga_clk_pkg;

  localparam logic [2:0] MODE_OFF  = 3'd0;
  localparam logic [2:0] MODE_PROG = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Requested divisor for a mode. Returned 32 bits wide so one function
  // serves every DIV_W; callers truncate to their own width.
  // MODE_OFF -> 0 (off), 1..6 -> 2^mode, MODE_PROG -> div_value (0 still means off).
  function automatic logic [31:0] decode_div(input logic [2:0] mode,
                                             input logic [31:0] div_value);
    logic [31:0] d;
    d = 32'd0;
    if (mode == MODE_OFF) begin
      d = 32'd0;
    end else if (mode == MODE_PROG) begin
      d = div_value;
    end else begin
      d = 32'd1 << mode;
    end
    return d;
  endfunction

endpackage

// File: rtl/vga_clk_divider_if.sv
// rtl/vga_clk_divider_if.sv - control/status bundle between the VGA timing block and the divider
// Ports (via modports):
//   master drives enable, mode, div_value; observes clock_div, tick, active_div, pending
//   slave  (the divider) is the mirror image
interface vga_clk_divider_if #(
  parameter int DIV_W  = 16,
  parameter int MODE_W = 3
);

  logic              enable;
  logic [MODE_W-1:0] mode;
  logic [DIV_W-1:0]  div_value;
  logic              clock_div;
  logic              tick;
  logic [DIV_W-1:0]  active_div;
  logic              pending;

  modport master (
    output enable, mode, div_value,
    input  clock_div, tick, active_div, pending
  );

  modport slave (
    input  enable, mode, div_value,
    output clock_div, tick, active_div, pending
  );

endinterface

// File: rtl/vga_div_counter.sv
// rtl/vga_div_counter.sv - modulo period counter with load, wrap flag and half-period compare
// Ports:
//   clock, reset   system clock, async active-high reset
//   advance        count one step (wraps to 0 at modulus-1)
//   load           force the count to 0 on this edge (wins over advance)
//   modulus        divisor of the period currently running
//   half_div       divisor that the next count value will belong to
//   wrap           count is at the last cycle of the period (modulus-1)
//   high_next      next count value lies in the high half of a half_div period
module vga_div_counter
  import vga_clk_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             advance,
  input  logic             load,
  input  logic [DIV_W-1:0] modulus,
  input  logic [DIV_W-1:0] half_div,
  output logic             wrap,
  output logic             high_next
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_next;
  logic [DIV_W:0]   half_ceil;

  // With modulus==0 the compare never matches; that only occurs while idle,
  // where advance is never asserted.
  assign wrap = (cnt_q == (modulus - {{(DIV_W-1){1'b0}}, 1'b1}));

  always_comb begin
    cnt_next = cnt_q;
    if (load) begin
      cnt_next = '0;
    end else if (advance) begin
      cnt_next = wrap ? '0 : (cnt_q + {{(DIV_W-1){1'b0}}, 1'b1});
    end
  end

  // ceil(D/2) in one extra bit so D = 2^DIV_W-1 cannot overflow.
  assign half_ceil = ({1'b0, half_div} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
  assign high_next = ({1'b0, cnt_next} < half_ceil);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_next;
    end
  end

endmodule

// File: rtl/vga_clk_divider.sv
// rtl/vga_clk_divider.sv - glitch-free run-time selectable clock-enable / divided-clock generator
// Ports:
//   clock, reset   system clock, async active-high reset
//   bus (slave)    enable, mode, div_value in; clock_div, tick, active_div, pending out
module vga_clk_divider
  import vga_clk_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int MODE_W     = 3,
  parameter int RESET_MODE = 0
) (
  input  logic             clock,
  input  logic             reset,
  vga_clk_divider_if.slave bus
);

  localparam logic [DIV_W-1:0] RESET_DIV =
    DIV_W'(decode_div(3'(RESET_MODE), 32'd0));

  state_t            state_q, state_nx;
  logic [DIV_W-1:0]  active_div_q, active_nx;
  logic              clock_div_q, clock_div_nx;
  logic              tick_q, tick_nx;
  logic              pending_q, pending_nx;

  logic [MODE_W-1:0] mode_s;
  logic [DIV_W-1:0]  req_d;
  logic              start;
  logic              wrap;
  logic              wrap_edge;
  logic              cnt_advance;
  logic              cnt_load;
  logic              high_next;

  assign mode_s = bus.mode;
  assign req_d  = DIV_W'(decode_div(3'(mode_s), 32'(bus.div_value)));

  // Leaving IDLE and the period boundary in RUN are the only two points at
  // which the requested ratio is allowed to take effect.
  assign start       = (state_q == IDLE) && bus.enable && (req_d != '0);
  assign wrap_edge   = (state_q == RUN) && bus.enable && wrap;
  assign cnt_advance = (state_q == RUN) && bus.enable;
  assign cnt_load    = start || (wrap_edge && (req_d == '0));

  // Boundary-switch logic: a request of 0 at the boundary lands active_div at 0.
  always_comb begin
    active_nx = active_div_q;
    if (start || wrap_edge) begin
      active_nx = req_d;
    end
  end

  vga_div_counter #(
    .DIV_W (DIV_W)
  ) u_counter (
    .clock     (clock),
    .reset     (reset),
    .advance   (cnt_advance),
    .load      (cnt_load),
    .modulus   (active_div_q),
    .half_div  (active_nx),
    .wrap      (wrap),
    .high_next (high_next)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      active_div_q <= RESET_DIV;
      clock_div_q  <= 1'b0;
      tick_q       <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_nx;
      active_div_q <= active_nx;
      clock_div_q  <= clock_div_nx;
      tick_q       <= tick_nx;
      pending_q    <= pending_nx;
    end
  end

  always_comb begin
    state_nx     = state_q;
    clock_div_nx = clock_div_q;
    tick_nx      = 1'b0;
    unique case (state_q)
      IDLE: begin
        clock_div_nx = 1'b0;
        if (start) begin
          state_nx     = RUN;
          tick_nx      = 1'b1;
          clock_div_nx = 1'b1;
        end
      end
      RUN: begin
        // enable low falls through: counter, clock_div and divisor hold.
        if (bus.enable) begin
          clock_div_nx = high_next;
          if (wrap) begin
            if (req_d == '0) begin
              state_nx     = IDLE;
              clock_div_nx = 1'b0;
            end else begin
              tick_nx = 1'b1;
            end
          end
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    pending_nx = (state_nx == RUN) && (req_d != active_nx);
  end

  assign bus.clock_div  = clock_div_q;
  assign bus.tick       = tick_q;
  assign bus.active_div = active_div_q;
  assign bus.pending    = pending_q;

endmodule
